spi_frame_streamer: RTL and testbench
=====================================

Name: spi_frame_streamer

Overview:
- SPI peripheral (mode 0, MSB first) in the sys_clk domain that lets the MCU poll frame status and stream the ready 1-bit/pixel frame out of the ping-pong SPRAM buffer.
- Drives the buffer's byte read address and consumes its combinational read data.
- Pulses frame_read_complete after the last byte of a frame transfer.
- Sits between the MCU SPI pins and the frame buffer.

Parameters:
- FRAME_BYTES, 9600, bytes per frame (76800 pixels / 8).
- ADDR_W, 17, width of the read address to the buffer.
- CMD_STATUS, 8'h01, command byte: return status.
- CMD_READ, 8'h02, command byte: stream frame.

Ports:
- sys_clk  in  1  system clock, 48 MHz
- nreset  in  1  asynchronous, active-low reset
- spi_sck  in  1  SPI clock from MCU, async; ≤ sys_clk/8
- spi_cs_n  in  1  chip select from MCU, async, active-low
- spi_mosi  in  1  MCU → FPGA data, async
- spi_miso  out  1  FPGA → MCU data
- spi_miso_oe  out  1  MISO tristate enable; high while synchronized CS is low
- buffer_ready  in  1  frame available in the read buffer
- rd_addr  out  ADDR_W  byte index into the read buffer, 0..FRAME_BYTES-1
- rd_data  in  8  byte at rd_addr; valid 1 sys_clk after rd_addr changes
- frame_read_complete  out  1  one-cycle pulse: frame fully shifted out
- busy  out  1  high in FRAME_TX

Behaviour:
- Reset: all outputs 0, state IDLE, bit_cnt=0, byte_cnt=0, shift register 0.
- Synchronization:
  - sck, cs_n and mosi each pass a 2-FF synchronizer plus a third stage for edge detect.
  - sck_rise = s2 & !s3; sck_fall = !s2 & s3.
  - MOSI is sampled from its s2 on sck_rise.
- CS high (synced), any state: return to IDLE next cycle.
  - Clear bit_cnt, byte_cnt and rd_addr; drive spi_miso=0.
  - No frame_read_complete pulse (abort).
  - Edges arriving with CS high are ignored.
- IDLE → CMD on synced CS fall. spi_miso=0 throughout the command byte.
- CMD:
  - Shift in 8 bits on sck_rise. At the 8th rise, decode:
  - CMD_STATUS → STATUS_TX. Load the shift register with {7'b0, buffer_ready}, sampled at that cycle.
  - CMD_READ with buffer_ready=1 → FRAME_TX. Set rd_addr=0; capture rd_data into the shift register 2 cycles later.
  - CMD_READ with buffer_ready=0, or any other code → DRAIN.
- Output timing:
  - On each sck_fall, spi_miso ← shift[7] and the register shifts left.
  - The first fall after the 8th rise of a byte presents the MSB of the next byte.
  - Prefetch budget is 3 sys_clk, guaranteed by SCK ≤ sys_clk/8 (half period ≥ 4 cycles).
- STATUS_TX: status byte re-sampled and repeated every byte until CS rises.
- FRAME_TX:
  - At the 8th rise of byte n, with n < FRAME_BYTES-1: rd_addr ← n+1, and the prefetched byte loads into the shift register before the next fall.
  - At the 8th rise of byte FRAME_BYTES-1: frame_read_complete=1 for exactly one cycle, then → DRAIN.
  - byte_cnt is 14 bits and never wraps past FRAME_BYTES-1.
- DRAIN: spi_miso=0, no reads, no pulses, until CS rises.
- buffer_ready falling mid-transfer: ignored; the transfer completes. The buffer owns swap safety.
- Reset asserted mid-transfer: immediate return to reset values; no complete pulse.
- rd_addr holds its value between updates; never exceeds FRAME_BYTES-1.

Decomposition:
- Package spi_frame_pkg: CMD_STATUS, CMD_READ, FRAME_BYTES, and the state enum {IDLE, CMD, STATUS_TX, FRAME_TX, DRAIN}.
- Sub-module spi_pin_sync: 3-stage synchronizer with rise/fall outputs, instantiated for sck and cs_n; mosi uses the synchronizer only.
- The top level holds the FSM, counters, prefetch and shift logic.

Test Plan:
- buffer_ready=1, CS low, send 8'h01 then 1 dummy byte at SCK=6 MHz → MISO returns 8'h01; no rd_addr change; no pulse.
- Buffer model returns rd_data = addr[7:0]^8'h5A. Send 8'h02, then 9600 dummy bytes → MISO bytes 0x5A,0x5B,… match for all 9600; rd_addr ends at 9599; exactly one frame_read_complete, on the 8th rise of byte 9599.
- buffer_ready=0, send 8'h02 + 4 bytes → MISO all 0x00; rd_addr stays 0; no pulse; busy stays 0.
- Send 8'h02, raise CS after byte 100, bit 3 → state IDLE, rd_addr=0, no pulse. A following full read transfer succeeds from byte 0.
- Send 8'h7E + 2 bytes → DRAIN, MISO 0x00, no reads.
- Assert nreset during byte 50 of a frame → all outputs 0 asynchronously. After release, a 8'h01 transaction returns the correct status.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared constants and FSM encoding for the SPI frame streamer.
package spi_frame_pkg;

   localparam int unsigned FRAME_BYTES = 9600;   // 76800 pixels at 1 bit/pixel
   localparam logic [7:0]  CMD_STATUS  = 8'h01;
   localparam logic [7:0]  CMD_READ    = 8'h02;

   typedef logic [2:0] state_t;

   localparam state_t IDLE      = 3'd0;
   localparam state_t CMD       = 3'd1;
   localparam state_t STATUS_TX = 3'd2;
   localparam state_t FRAME_TX  = 3'd3;
   localparam state_t DRAIN     = 3'd4;

endpackage

// File: rtl/spi_pin_sync.sv
// Three-stage synchronizer for an asynchronous SPI pin. The first two stages
// resolve metastability; the third provides the edge-detect history.
module spi_pin_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic sys_clk,
   input  logic nreset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   // Shift the raw pin through the synchronizer chain.
   always_ff @(posedge sys_clk or negedge nreset) begin
      if (!nreset) begin
         s1 <= RESET_VAL;
         s2 <= RESET_VAL;
         s3 <= RESET_VAL;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the previous
         // stage's old value, giving a true chain instead of one flop.
         s1 <= pin;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_frame_streamer.sv
// SPI mode-0 peripheral that reports frame status or streams the ready frame
// out of the read buffer. All SPI pins are oversampled in the sys_clk domain.
module spi_frame_streamer #(
   parameter int unsigned FRAME_BYTES = spi_frame_pkg::FRAME_BYTES,
   parameter int unsigned ADDR_W      = 17,
   parameter logic [7:0]  CMD_STATUS  = spi_frame_pkg::CMD_STATUS,
   parameter logic [7:0]  CMD_READ    = spi_frame_pkg::CMD_READ
) (
   input  logic              sys_clk,
   input  logic              nreset,
   input  logic              spi_sck,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic              buffer_ready,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              frame_read_complete,
   output logic              busy
);

   import spi_frame_pkg::*;

   localparam logic [13:0] LAST_BYTE = 14'(FRAME_BYTES - 1);

   logic       sck_level, sck_rise, sck_fall;
   logic       cs_level, cs_rise, cs_fall;
   logic       mosi_s1, mosi_s2;
   logic       unused_sync;

   state_t      state;
   logic [2:0]  bit_cnt;
   logic [13:0] byte_cnt;
   logic [6:0]  rx_reg;
   logic [7:0]  shift_reg;
   logic [1:0]  pf_cnt;     // counts down to the cycle rd_data is captured
   logic [7:0]  cmd_byte;

   spi_pin_sync #(.RESET_VAL(1'b0)) u_sck_sync (
      .sys_clk (sys_clk),
      .nreset  (nreset),
      .pin     (spi_sck),
      .level   (sck_level),
      .rise    (sck_rise),
      .fall    (sck_fall)
   );

   // CS resets to the deasserted level so the MISO enable stays low in reset.
   spi_pin_sync #(.RESET_VAL(1'b1)) u_cs_sync (
      .sys_clk (sys_clk),
      .nreset  (nreset),
      .pin     (spi_cs_n),
      .level   (cs_level),
      .rise    (cs_rise),
      .fall    (cs_fall)
   );

   // The SCK level and CS rise are not needed; CS level alone drives the abort.
   assign unused_sync = sck_level ^ cs_rise;

   // Two-stage synchronizer for MOSI, aligned with the SCK s2 stage.
   always_ff @(posedge sys_clk or negedge nreset) begin
      if (!nreset) begin
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         mosi_s1 <= spi_mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   // The command byte as it will read once the current MOSI bit is shifted in.
   assign cmd_byte = {rx_reg, mosi_s2};

   // Transaction FSM: command decode, status/frame shift-out, prefetch and abort.
   always_ff @(posedge sys_clk or negedge nreset) begin
      if (!nreset) begin
         state               <= IDLE;
         bit_cnt             <= 3'd0;
         byte_cnt            <= 14'd0;
         rx_reg              <= 7'd0;
         shift_reg           <= 8'd0;
         pf_cnt              <= 2'd0;
         rd_addr             <= '0;
         spi_miso            <= 1'b0;
         frame_read_complete <= 1'b0;
      end else begin
         frame_read_complete <= 1'b0;

         // Prefetch: the buffer needs one cycle after rd_addr moves, so the
         // byte is captured on the second cycle after the address update.
         if (pf_cnt != 2'd0) pf_cnt <= pf_cnt - 2'd1;
         if (pf_cnt == 2'd1) shift_reg <= rd_data;

         if (cs_level) begin
            // CS deasserted: abandon whatever was in flight, no completion.
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 14'd0;
            rd_addr   <= '0;
            spi_miso  <= 1'b0;
            pf_cnt    <= 2'd0;
            shift_reg <= 8'd0;
         end else begin
            case (state)
               IDLE: begin
                  spi_miso <= 1'b0;
                  if (cs_fall) begin
                     state   <= CMD;
                     bit_cnt <= 3'd0;
                     rx_reg  <= 7'd0;
                  end
               end

               CMD: begin
                  if (sck_fall) spi_miso <= 1'b0;
                  if (sck_rise) begin
                     rx_reg  <= cmd_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (cmd_byte == CMD_STATUS) begin
                           state     <= STATUS_TX;
                           shift_reg <= {7'd0, buffer_ready};
                        end else if (cmd_byte == CMD_READ && buffer_ready) begin
                           state    <= FRAME_TX;
                           rd_addr  <= '0;
                           byte_cnt <= 14'd0;
                           pf_cnt   <= 2'd2;
                        end else begin
                           state <= DRAIN;
                        end
                     end
                  end
               end

               STATUS_TX: begin
                  if (sck_fall) begin
                     spi_miso  <= shift_reg[7];
                     shift_reg <= {shift_reg[6:0], 1'b0};
                  end
                  if (sck_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) shift_reg <= {7'd0, buffer_ready};
                  end
               end

               FRAME_TX: begin
                  if (sck_fall) begin
                     spi_miso  <= shift_reg[7];
                     shift_reg <= {shift_reg[6:0], 1'b0};
                  end
                  if (sck_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (byte_cnt == LAST_BYTE) begin
                           frame_read_complete <= 1'b1;
                           state               <= DRAIN;
                        end else begin
                           byte_cnt <= byte_cnt + 14'd1;
                           rd_addr  <= ADDR_W'(byte_cnt + 14'd1);
                           pf_cnt   <= 2'd2;
                        end
                     end
                  end
               end

               DRAIN: begin
                  spi_miso <= 1'b0;
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign busy        = (state == FRAME_TX);
   assign spi_miso_oe = ~cs_level;

endmodule

// File: tb/tb_spi_frame_streamer.sv
// Directed bench for spi_frame_streamer: status polling, full frame stream,
// not-ready read, CS abort, unknown command and mid-frame reset.
module tb_spi_frame_streamer;

   localparam int FB   = 128;   // shortened frame keeps the run small
   localparam int AW   = 17;
   localparam int HALF = 4;     // sys_clk cycles per SCK half period (sys_clk/8)

   logic          sys_clk      = 1'b0;
   logic          nreset       = 1'b1;
   logic          spi_sck      = 1'b0;
   logic          spi_cs_n     = 1'b1;
   logic          spi_mosi     = 1'b0;
   logic          buffer_ready = 1'b0;
   logic          spi_miso;
   logic          spi_miso_oe;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data      = 8'h00;
   logic          frame_read_complete;
   logic          busy;

   int tests        = 0;
   int fails        = 0;
   int pulses       = 0;
   int busy_cycles  = 0;
   int addr_changes = 0;
   logic [AW-1:0] rd_prev = '0;

   always #10 sys_clk = ~sys_clk;

   spi_frame_streamer #(
      .FRAME_BYTES (FB),
      .ADDR_W      (AW),
      .CMD_STATUS  (8'h01),
      .CMD_READ    (8'h02)
   ) dut (
      .sys_clk             (sys_clk),
      .nreset              (nreset),
      .spi_sck             (spi_sck),
      .spi_cs_n            (spi_cs_n),
      .spi_mosi            (spi_mosi),
      .spi_miso            (spi_miso),
      .spi_miso_oe         (spi_miso_oe),
      .buffer_ready        (buffer_ready),
      .rd_addr             (rd_addr),
      .rd_data             (rd_data),
      .frame_read_complete (frame_read_complete),
      .busy                (busy)
   );

   // Buffer model: data valid one cycle after the address changes.
   always @(posedge sys_clk) rd_data <= rd_addr[7:0] ^ 8'h5A;

   // Event counters for pulses, busy time and buffer address movement.
   always @(posedge sys_clk) begin
      rd_prev <= rd_addr;
      if (frame_read_complete) pulses <= pulses + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (rd_addr != rd_prev) addr_changes <= addr_changes + 1;
   end

   // Watchdog so the run always ends.
   initial begin
      #4ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Mode-0 transfer of the top nbits of tx; MISO sampled at each SCK rise.
   task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spi_mosi = tx[i];
         repeat (HALF) @(negedge sys_clk);
         rx[i]   = spi_miso;
         spi_sck = 1'b1;
         repeat (HALF) @(negedge sys_clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic cs_low();
      @(negedge sys_clk);
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge sys_clk);
   endtask

   task automatic cs_high();
      repeat (HALF) @(negedge sys_clk);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge sys_clk);
   endtask

   // Complete frame read: command, FB bytes, pulse exactly at the last byte.
   task automatic full_read(input string name);
      logic [7:0] rx;
      int p0;
      p0 = pulses;
      cs_low();
      spi_byte(8'h02, 8, rx);
      check({name, " cmd miso"}, 32'(rx), 32'h0);
      for (int n = 0; n < FB; n++) begin
         if (n == FB - 1) check({name, " no early pulse"}, 32'(pulses - p0), 32'd0);
         spi_byte(8'h00, 8, rx);
         check($sformatf("%s byte[%0d]", name, n), 32'(rx), 32'(n[7:0] ^ 8'h5A));
      end
      repeat (2) @(negedge sys_clk);
      check({name, " one pulse"}, 32'(pulses - p0), 32'd1);
      check({name, " rd_addr end"}, 32'(rd_addr), 32'(FB - 1));
      check({name, " busy after last"}, 32'(busy), 32'd0);
      cs_high();
      check({name, " rd_addr cleared"}, 32'(rd_addr), 32'd0);
   endtask

   initial begin
      logic [7:0] rx;
      int p0, b0, a0;

      // Reset state
      #3 nreset = 1'b0;
      repeat (4) @(negedge sys_clk);
      check("reset miso", 32'(spi_miso), 32'd0);
      check("reset miso_oe", 32'(spi_miso_oe), 32'd0);
      check("reset rd_addr", 32'(rd_addr), 32'd0);
      check("reset complete", 32'(frame_read_complete), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      nreset = 1'b1;
      repeat (4) @(negedge sys_clk);

      // Status poll, re-sampled each byte
      p0 = pulses; a0 = addr_changes;
      buffer_ready = 1'b1;
      cs_low();
      check("status miso_oe", 32'(spi_miso_oe), 32'd1);
      spi_byte(8'h01, 8, rx);
      check("status cmd miso", 32'(rx), 32'h0);
      buffer_ready = 1'b0;
      spi_byte(8'h00, 8, rx);
      check("status byte0", 32'(rx), 32'h01);
      spi_byte(8'h00, 8, rx);
      check("status byte1 resampled", 32'(rx), 32'h00);
      cs_high();
      check("status miso_oe off", 32'(spi_miso_oe), 32'd0);
      check("status no pulse", 32'(pulses - p0), 32'd0);
      check("status no addr change", 32'(addr_changes - a0), 32'd0);

      // Full frame stream
      buffer_ready = 1'b1;
      full_read("frame1");

      // Read with buffer not ready
      buffer_ready = 1'b0;
      p0 = pulses; b0 = busy_cycles; a0 = addr_changes;
      cs_low();
      spi_byte(8'h02, 8, rx);
      for (int n = 0; n < 4; n++) begin
         spi_byte(8'h00, 8, rx);
         check($sformatf("notready byte[%0d]", n), 32'(rx), 32'h0);
      end
      check("notready rd_addr", 32'(rd_addr), 32'd0);
      cs_high();
      check("notready no pulse", 32'(pulses - p0), 32'd0);
      check("notready busy", 32'(busy_cycles - b0), 32'd0);
      check("notready no addr change", 32'(addr_changes - a0), 32'd0);

      // CS abort at byte 100, bit 3
      buffer_ready = 1'b1;
      p0 = pulses;
      cs_low();
      spi_byte(8'h02, 8, rx);
      for (int n = 0; n < 100; n++) begin
         spi_byte(8'h00, 8, rx);
         check($sformatf("abort byte[%0d]", n), 32'(rx), 32'(n[7:0] ^ 8'h5A));
      end
      spi_byte(8'h00, 3, rx);
      check("abort busy before", 32'(busy), 32'd1);
      check("abort rd_addr before", 32'(rd_addr), 32'd100);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge sys_clk);
      check("abort rd_addr", 32'(rd_addr), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort miso_oe", 32'(spi_miso_oe), 32'd0);
      check("abort miso", 32'(spi_miso), 32'd0);
      check("abort no pulse", 32'(pulses - p0), 32'd0);
      full_read("frame2");

      // Unknown command drains
      p0 = pulses; b0 = busy_cycles; a0 = addr_changes;
      cs_low();
      spi_byte(8'h7E, 8, rx);
      check("unknown cmd miso", 32'(rx), 32'h0);
      for (int n = 0; n < 2; n++) begin
         spi_byte(8'hFF, 8, rx);
         check($sformatf("unknown byte[%0d]", n), 32'(rx), 32'h0);
      end
      cs_high();
      check("unknown busy", 32'(busy_cycles - b0), 32'd0);
      check("unknown no addr change", 32'(addr_changes - a0), 32'd0);
      check("unknown no pulse", 32'(pulses - p0), 32'd0);

      // Reset mid-frame at byte 50
      p0 = pulses;
      cs_low();
      spi_byte(8'h02, 8, rx);
      for (int n = 0; n < 50; n++) spi_byte(8'h00, 8, rx);
      spi_byte(8'h00, 4, rx);
      check("midreset busy before", 32'(busy), 32'd1);
      #3 nreset = 1'b0;
      #1;
      check("midreset rd_addr", 32'(rd_addr), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset miso", 32'(spi_miso), 32'd0);
      check("midreset miso_oe", 32'(spi_miso_oe), 32'd0);
      check("midreset complete", 32'(frame_read_complete), 32'd0);
      spi_cs_n = 1'b1;
      spi_sck  = 1'b0;
      repeat (4) @(negedge sys_clk);
      nreset = 1'b1;
      repeat (4) @(negedge sys_clk);
      check("midreset no pulse", 32'(pulses - p0), 32'd0);
      cs_low();
      spi_byte(8'h01, 8, rx);
      spi_byte(8'h00, 8, rx);
      check("post-reset status", 32'(rx), 32'h01);
      cs_high();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
